// File: rtl/axi_lite_reg_slave.sv
// -----------------------------------------------------------------------------
// axi_lite_reg_slave
//   AXI4-Lite register slave with four 32-bit locations:
//     0x0 REG0 (RW), 0x4 REG1 (RW), 0x8 WCNT (RO), 0xC SUM = REG0+REG1 (RO).
//   An address decodes only when addr[7:4]==0; addr[1:0] is ignored.
//   One outstanding write and one outstanding read, served by independent FSMs.
//
//   Optional feature: define REG_WRITE_COUNTER_EN to build the WCNT counter,
//   which counts OKAY writes to REG0/REG1. Without it WCNT reads as 0.
//
// Handshake rule (all five channels): a transfer happens on the rising edge
// where valid && ready are both high. A source holds valid and payload stable
// until that edge. All readies are registered and depend only on FSM state.
//
// Ports
//   s_axi_aclk, s_axi_aresetn     clock, asynchronous active-low reset
//   s_axi_aw*                     write address channel
//   s_axi_w*                      write data channel (wstrb = byte enables)
//   s_axi_b*                      write response channel (OKAY=0, SLVERR=2)
//   s_axi_ar*                     read address channel
//   s_axi_r*                      read data channel
//   wr_state_dbg, rd_state_dbg    current write / read FSM state (debug)
// -----------------------------------------------------------------------------
module axi_lite_reg_slave #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int RESP_WIDTH = 2
) (
   input  logic                    s_axi_aclk,
   input  logic                    s_axi_aresetn,
   input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic                    s_axi_awvalid,
   output logic                    s_axi_awready,
   input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                    s_axi_wvalid,
   output logic                    s_axi_wready,
   output logic [RESP_WIDTH-1:0]   s_axi_bresp,
   output logic                    s_axi_bvalid,
   input  logic                    s_axi_bready,
   input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic                    s_axi_arvalid,
   output logic                    s_axi_arready,
   output logic [DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [RESP_WIDTH-1:0]   s_axi_rresp,
   output logic                    s_axi_rvalid,
   input  logic                    s_axi_rready,
   output logic [1:0]              wr_state_dbg,
   output logic                    rd_state_dbg
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = '0;
   localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

   typedef enum logic [1:0] {WR_IDLE, WR_HAVE_ADDR, WR_HAVE_DATA, WR_RESP} wr_state_t;
   typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

   wr_state_t wr_state, wr_next;
   rd_state_t rd_state, rd_next;

   logic [DATA_WIDTH-1:0] reg0, reg1, wcnt;
   logic [ADDR_WIDTH-1:0] aw_addr_q;
   logic [DATA_WIDTH-1:0] w_data_q;
   logic [STRB_W-1:0]     w_strb_q;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
   assign aw_hs = s_axi_awvalid && s_axi_awready;
   assign w_hs  = s_axi_wvalid  && s_axi_wready;
   assign b_hs  = s_axi_bvalid  && s_axi_bready;
   assign ar_hs = s_axi_arvalid && s_axi_arready;
   assign r_hs  = s_axi_rvalid  && s_axi_rready;

   assign wr_state_dbg = wr_state;
   assign rd_state_dbg = rd_state;

   function automatic logic [DATA_WIDTH-1:0] byte_merge(
      input logic [DATA_WIDTH-1:0] old_v,
      input logic [DATA_WIDTH-1:0] new_v,
      input logic [STRB_W-1:0]     strb
   );
      byte_merge = old_v;
      for (int i = 0; i < STRB_W; i++) begin
         if (strb[i]) byte_merge[8*i +: 8] = new_v[8*i +: 8];
      end
   endfunction

   // ---------------------------------------------------------------- write FSM
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) wr_state <= WR_IDLE;
      else                wr_state <= wr_next;
   end

   always_comb begin
      wr_next = wr_state;
      case (wr_state)
         WR_IDLE: begin
            if (aw_hs && w_hs) wr_next = WR_RESP;
            else if (aw_hs)    wr_next = WR_HAVE_ADDR;
            else if (w_hs)     wr_next = WR_HAVE_DATA;
         end
         WR_HAVE_ADDR: if (w_hs)  wr_next = WR_RESP;
         WR_HAVE_DATA: if (aw_hs) wr_next = WR_RESP;
         WR_RESP:      if (b_hs)  wr_next = WR_IDLE;
         default:      wr_next = WR_IDLE;
      endcase
   end

   // The completing handshake's payload is still on the bus this cycle, so
   // take it directly rather than from the holding registers.
   logic                  wr_commit;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [STRB_W-1:0]     wr_strb;
   logic                  wr_decoded;
   logic [1:0]            wr_sel;

   assign wr_commit  = (wr_state != WR_RESP) && (wr_next == WR_RESP);
   assign wr_addr    = aw_hs ? s_axi_awaddr : aw_addr_q;
   assign wr_data    = w_hs  ? s_axi_wdata  : w_data_q;
   assign wr_strb    = w_hs  ? s_axi_wstrb  : w_strb_q;
   assign wr_decoded = (wr_addr >> 4) == '0;
   assign wr_sel     = wr_addr[3:2];

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         s_axi_awready <= 1'b0;
         s_axi_wready  <= 1'b0;
         s_axi_bvalid  <= 1'b0;
         s_axi_bresp   <= RESP_OKAY;
         aw_addr_q     <= '0;
         w_data_q      <= '0;
         w_strb_q      <= '0;
      end else begin
         s_axi_awready <= (wr_next == WR_IDLE) || (wr_next == WR_HAVE_DATA);
         s_axi_wready  <= (wr_next == WR_IDLE) || (wr_next == WR_HAVE_ADDR);
         s_axi_bvalid  <= (wr_next == WR_RESP);
         if (aw_hs) aw_addr_q <= s_axi_awaddr;
         if (w_hs) begin
            w_data_q <= s_axi_wdata;
            w_strb_q <= s_axi_wstrb;
         end
         if (wr_commit) s_axi_bresp <= wr_decoded ? RESP_OKAY : RESP_SLVERR;
      end
   end

   // Registers update with NBAs, so a read captured on the same edge sees
   // the pre-write value.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         reg0 <= '0;
         reg1 <= '0;
      end else if (wr_commit && wr_decoded) begin
         case (wr_sel)
            2'd0:    reg0 <= byte_merge(reg0, wr_data, wr_strb);
            2'd1:    reg1 <= byte_merge(reg1, wr_data, wr_strb);
            default: ;
         endcase
      end
   end

`ifdef REG_WRITE_COUNTER_EN
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn)
         wcnt <= '0;
      else if (wr_commit && wr_decoded && !wr_sel[1])
         wcnt <= wcnt + DATA_WIDTH'(1);
   end
`else
   assign wcnt = '0;
`endif

   // ----------------------------------------------------------------- read FSM
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) rd_state <= RD_IDLE;
      else                rd_state <= rd_next;
   end

   always_comb begin
      rd_next = rd_state;
      case (rd_state)
         RD_IDLE: if (ar_hs) rd_next = RD_DATA;
         RD_DATA: if (r_hs)  rd_next = RD_IDLE;
         default: rd_next = RD_IDLE;
      endcase
   end

   logic [DATA_WIDTH-1:0] rd_value;
   logic [RESP_WIDTH-1:0] rd_resp_val;

   always_comb begin
      rd_value    = '0;
      rd_resp_val = RESP_SLVERR;
      if ((s_axi_araddr >> 4) == '0) begin
         rd_resp_val = RESP_OKAY;
         case (s_axi_araddr[3:2])
            2'd0:    rd_value = reg0;
            2'd1:    rd_value = reg1;
            2'd2:    rd_value = wcnt;
            default: rd_value = reg0 + reg1;
         endcase
      end
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         s_axi_arready <= 1'b0;
         s_axi_rvalid  <= 1'b0;
         s_axi_rdata   <= '0;
         s_axi_rresp   <= RESP_OKAY;
      end else begin
         s_axi_arready <= (rd_next == RD_IDLE);
         s_axi_rvalid  <= (rd_next == RD_DATA);
         if (ar_hs) begin
            s_axi_rdata <= rd_value;
            s_axi_rresp <= rd_resp_val;
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_reg_slave
//   Directed and randomized AXI4-Lite traffic against axi_lite_reg_slave.
//   Expected read data comes from a register-map model kept in this file.
// -----------------------------------------------------------------------------
module tb_axi_lite_reg_slave;

   // ------------------------------------------------------- clock / reset
   logic        s_axi_aclk;
   logic        s_axi_aresetn;

   initial s_axi_aclk = 1'b0;
   always #5 s_axi_aclk = ~s_axi_aclk;

   logic [7:0]  s_axi_awaddr;
   logic        s_axi_awvalid;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_wvalid;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready;
   logic [7:0]  s_axi_araddr;
   logic        s_axi_arvalid;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready;
   logic [1:0]  wr_state_dbg;
   logic        rd_state_dbg;

   axi_lite_reg_slave dut (
      .s_axi_aclk    (s_axi_aclk),
      .s_axi_aresetn (s_axi_aresetn),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_bresp   (s_axi_bresp),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rresp   (s_axi_rresp),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready),
      .wr_state_dbg  (wr_state_dbg),
      .rd_state_dbg  (rd_state_dbg)
   );

   // ------------------------------------------------------- scoreboard
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ------------------------------------------------------- reference model
   logic [31:0] m_regs [2];
   logic [31:0] m_wcnt;

   function automatic void model_reset();
      m_regs[0] = 32'h0;
      m_regs[1] = 32'h0;
      m_wcnt    = 32'h0;
   endfunction

   function automatic logic [1:0] model_write(input logic [7:0] addr, input logic [31:0] data,
                                              input logic [3:0] strb);
      int idx;
      if (addr[7:4] != 4'h0) return 2'd2;
      idx = int'(addr[3:2]);
      if (idx < 2) begin
         for (int b = 0; b < 4; b++)
            if (strb[b]) m_regs[idx][8*b +: 8] = data[8*b +: 8];
`ifdef REG_WRITE_COUNTER_EN
         m_wcnt = m_wcnt + 32'd1;
`endif
      end
      return 2'd0;
   endfunction

   function automatic void model_read(input logic [7:0] addr, output logic [31:0] data,
                                      output logic [1:0] resp);
      data = 32'h0;
      resp = 2'd2;
      if (addr[7:4] == 4'h0) begin
         resp = 2'd0;
         case (addr[3:2])
            2'd0: data = m_regs[0];
            2'd1: data = m_regs[1];
            2'd2: data = m_wcnt;
            default: data = m_regs[0] + m_regs[1];
         endcase
      end
   endfunction

   // ------------------------------------------------------- driver tasks
   task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
      logic aw_done = 1'b0;
      logic w_done  = 1'b0;
      logic hs_aw, hs_w;
      logic [1:0] exp_resp;
      int cyc = 0;
      exp_resp = model_write(addr, data, strb);
      while (!(aw_done && w_done) && cyc < 50) begin
         @(negedge s_axi_aclk);
         s_axi_awaddr  = addr;
         s_axi_wdata   = data;
         s_axi_wstrb   = strb;
         s_axi_awvalid = !aw_done && (cyc >= aw_dly);
         s_axi_wvalid  = !w_done && (cyc >= w_dly);
         check("bvalid_early", s_axi_bvalid, 0);
         if (w_done && !aw_done) check("wready_wait_aw", s_axi_wready, 0);
         if (aw_done && !w_done) check("awready_wait_w", s_axi_awready, 0);
         hs_aw = s_axi_awvalid && s_axi_awready;
         hs_w  = s_axi_wvalid && s_axi_wready;
         @(posedge s_axi_aclk);
         aw_done = aw_done | hs_aw;
         w_done  = w_done | hs_w;
         cyc++;
      end
      @(negedge s_axi_aclk);
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      if (!(aw_done && w_done)) check("wr_timeout", 0, 1);
      check("bvalid_latency", s_axi_bvalid, 1);
      check("bresp", s_axi_bresp, exp_resp);
      repeat (b_dly) begin
         @(negedge s_axi_aclk);
         check("bvalid_hold", s_axi_bvalid, 1);
         check("bresp_hold", s_axi_bresp, exp_resp);
         check("aw_w_ready_hold", {s_axi_awready, s_axi_wready}, 2'b00);
      end
      s_axi_bready = 1'b1;
      @(posedge s_axi_aclk);
      @(negedge s_axi_aclk);
      s_axi_bready = 1'b0;
      check("bvalid_clear", s_axi_bvalid, 0);
   endtask

   task automatic axi_read(input logic [7:0] addr, input int ar_dly, input int r_dly);
      logic [31:0] exp_d, held;
      logic [1:0]  exp_r;
      logic done = 1'b0;
      logic hs;
      int cyc = 0;
      model_read(addr, exp_d, exp_r);
      exp_q.push_back(exp_d);
      while (!done && cyc < 50) begin
         @(negedge s_axi_aclk);
         s_axi_araddr  = addr;
         s_axi_arvalid = (cyc >= ar_dly);
         check("rvalid_early", s_axi_rvalid, 0);
         hs = s_axi_arvalid && s_axi_arready;
         @(posedge s_axi_aclk);
         done = hs;
         cyc++;
      end
      @(negedge s_axi_aclk);
      s_axi_arvalid = 1'b0;
      if (!done) check("rd_timeout", 0, 1);
      check("rvalid_latency", s_axi_rvalid, 1);
      check("rresp", s_axi_rresp, exp_r);
      held = s_axi_rdata;
      repeat (r_dly) begin
         @(negedge s_axi_aclk);
         check("rvalid_hold", s_axi_rvalid, 1);
         check("rdata_hold", s_axi_rdata, held);
         check("arready_hold", s_axi_arready, 0);
      end
      s_axi_rready = 1'b1;
      check("rdata", s_axi_rdata, exp_q.pop_front());
      @(posedge s_axi_aclk);
      @(negedge s_axi_aclk);
      s_axi_rready = 1'b0;
      check("rvalid_clear", s_axi_rvalid, 0);
   endtask

   // Issue AW+W+AR on the same edge and leave both responses pending.
   task automatic issue_rw_same_edge(input logic [7:0] addr, input logic [31:0] data);
      @(negedge s_axi_aclk);
      check("idle_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
      s_axi_awaddr  = addr;
      s_axi_wdata   = data;
      s_axi_wstrb   = 4'hF;
      s_axi_araddr  = addr;
      s_axi_awvalid = 1'b1;
      s_axi_wvalid  = 1'b1;
      s_axi_arvalid = 1'b1;
      @(posedge s_axi_aclk);
      @(negedge s_axi_aclk);
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      s_axi_arvalid = 1'b0;
      check("same_edge_valids", {s_axi_bvalid, s_axi_rvalid}, 2'b11);
   endtask

   function automatic logic [7:0] rand_addr();
      if ($urandom_range(0, 5) < 5)
         return {4'h0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      return {4'($urandom_range(1, 15)), 4'($urandom_range(0, 15))};
   endfunction

   // ------------------------------------------------------- main sequence
   logic [31:0] old_v, got_d;
   logic [1:0]  dummy_resp;

   initial begin
      s_axi_aresetn = 1'b0;
      s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
      s_axi_wdata  = '0; s_axi_wstrb   = '0; s_axi_wvalid = 1'b0;
      s_axi_bready = 1'b0;
      s_axi_araddr = '0; s_axi_arvalid = 1'b0;
      s_axi_rready = 1'b0;
      model_reset();

      // Outputs during reset, then readies one edge after release.
      repeat (3) @(negedge s_axi_aclk);
      check("reset_outputs",
            {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready,
             s_axi_rvalid, s_axi_rresp, s_axi_rdata}, 64'h0);
      s_axi_aresetn = 1'b1;
      @(negedge s_axi_aclk);
      check("readies_after_reset", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

      // Same-cycle AW/W, then read back.
      axi_write(8'h00, 32'h1234_5678, 4'hF, 0, 0, 0);
      axi_read(8'h00, 0, 0);

      // W three cycles ahead of AW, partial strobes.
      axi_write(8'h04, 32'hAABB_CCDD, 4'h5, 3, 0, 0);
      axi_read(8'h04, 0, 0);

      // Undecoded accesses and read-only targets.
      axi_write(8'h40, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
      axi_read(8'h80, 0, 0);
      axi_write(8'h08, 32'h5555_5555, 4'hF, 0, 1, 0);
      axi_write(8'h0C, 32'h6666_6666, 4'hF, 1, 0, 0);
      axi_write(8'h00, 32'h9999_9999, 4'h0, 0, 0, 0);
      axi_read(8'h00, 0, 0);
      axi_read(8'h04, 0, 0);

      // SUM wraps modulo 2^32.
      axi_write(8'h00, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
      axi_write(8'h04, 32'h0000_0002, 4'hF, 0, 0, 0);
      axi_read(8'h0C, 0, 0);
      axi_read(8'h08, 0, 0);

      // Long backpressure on both response channels.
      axi_write(8'h04, 32'h0BAD_F00D, 4'hF, 0, 0, 5);
      axi_read(8'h04, 0, 5);

      // Read and write of REG0 completing on the same edge.
      old_v = m_regs[0];
      issue_rw_same_edge(8'h00, 32'hCAFE_0001);
      check("same_edge_rdata", s_axi_rdata, old_v);
      dummy_resp = model_write(8'h00, 32'hCAFE_0001, 4'hF);
      check("same_edge_bresp", s_axi_bresp, dummy_resp);
      s_axi_bready = 1'b1;
      s_axi_rready = 1'b1;
      @(posedge s_axi_aclk);
      @(negedge s_axi_aclk);
      s_axi_bready = 1'b0;
      s_axi_rready = 1'b0;
      axi_read(8'h00, 0, 0);

      // Randomized traffic.
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 1) == 0)
            axi_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         else
            axi_read(rand_addr(), $urandom_range(0, 3), $urandom_range(0, 3));
      end
      axi_read(8'h08, 0, 0);
      axi_read(8'h0C, 0, 0);

      // Asynchronous reset while both responses are held.
      issue_rw_same_edge(8'h04, 32'h7777_8888);
      repeat (2) begin
         @(negedge s_axi_aclk);
         check("pending_hold", {s_axi_bvalid, s_axi_rvalid}, 2'b11);
      end
      #2 s_axi_aresetn = 1'b0;
      #1;
      check("reset_async_outputs",
            {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready,
             s_axi_rvalid, s_axi_rresp, s_axi_rdata}, 64'h0);
      model_reset();
      @(negedge s_axi_aclk);
      s_axi_aresetn = 1'b1;
      @(negedge s_axi_aclk);
      check("readies_after_reset2", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
      axi_read(8'h00, 0, 0);
      axi_read(8'h04, 0, 0);
      axi_read(8'h08, 0, 0);

      // Partial write (AW only) dropped by reset must not update REG0.
      @(negedge s_axi_aclk);
      s_axi_awaddr  = 8'h00;
      s_axi_awvalid = 1'b1;
      @(posedge s_axi_aclk);
      @(negedge s_axi_aclk);
      s_axi_awvalid = 1'b0;
      s_axi_wdata   = 32'h1111_2222;
      s_axi_wstrb   = 4'hF;
      #2 s_axi_aresetn = 1'b0;
      @(negedge s_axi_aclk);
      s_axi_aresetn = 1'b1;
      @(negedge s_axi_aclk);
      model_read(8'h00, got_d, dummy_resp);
      axi_read(8'h00, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
      $fatal(1, "watchdog");
   end

endmodule
